// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order multi-slot retirement,
// out-of-order completion by tag and precise exception flush.
`ifndef PROJ_NUM_ARCH_REGS
`define PROJ_NUM_ARCH_REGS 32
`endif
`ifndef PROJ_NUM_PHYS_REGS
`define PROJ_NUM_PHYS_REGS 64
`endif

module rob_multi_commit #(
  parameter int SIZE          = 64,
  parameter int NUM_ARCH_REGS = `PROJ_NUM_ARCH_REGS,
  parameter int NUM_PHYS_REGS = `PROJ_NUM_PHYS_REGS,
  parameter int COMMIT_WIDTH  = 2,
  localparam int LT = $clog2(SIZE),
  localparam int LA = $clog2(NUM_ARCH_REGS),
  localparam int LP = $clog2(NUM_PHYS_REGS),
  localparam int CW = COMMIT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Disp_valid_IN,
  input  logic             Disp_has_dest_IN,
  input  logic [LA-1:0]    Disp_arch_IN,
  input  logic [LP-1:0]    Disp_phys_IN,
  input  logic [LP-1:0]    Disp_old_phys_IN,
  output logic             Disp_ready_OUT,
  output logic [LT-1:0]    Disp_tag_OUT,
  input  logic             Cmpl_valid_IN,
  input  logic [LT-1:0]    Cmpl_tag_IN,
  input  logic             Cmpl_exc_IN,
  output logic [CW-1:0]    Commit_valid_OUT,
  output logic [CW-1:0]    Commit_has_dest_OUT,
  output logic [CW*LA-1:0] Commit_arch_OUT,
  output logic [CW*LP-1:0] Commit_phys_OUT,
  output logic [CW*LP-1:0] Commit_free_OUT,
  output logic             Flush_OUT,
  output logic [LT:0]      Count_OUT,
  output logic             Full_OUT,
  output logic             Empty_OUT
);

  localparam logic [LT:0] FULL_CNT = (LT+1)'(SIZE);

  logic [SIZE-1:0] e_valid;
  logic [SIZE-1:0] e_done;
  logic [SIZE-1:0] e_exc;
  logic [SIZE-1:0] e_has_dest;
  logic [LA-1:0]   e_arch [SIZE];
  logic [LP-1:0]   e_phys [SIZE];
  logic [LP-1:0]   e_old  [SIZE];

  logic [LT-1:0] head;
  logic [LT-1:0] tail;
  logic [LT:0]   count;

  logic          full;
  logic          flush;
  logic          disp_acc;
  logic          cmpl_hit;
  logic          scan_go;
  logic [CW-1:0] pop;
  logic [LT:0]   k;
  logic [LT-1:0] slot_idx [CW];

  assign full     = (count == FULL_CNT);
  assign flush    = e_valid[head] & e_done[head] & e_exc[head];
  assign disp_acc = Disp_valid_IN & ~full & ~flush;
  assign cmpl_hit = Cmpl_valid_IN & e_valid[Cmpl_tag_IN] & ~flush;

  assign Disp_ready_OUT = ~full;
  assign Disp_tag_OUT   = tail;
  assign Count_OUT      = count;
  assign Full_OUT       = full;
  assign Empty_OUT      = (count == '0);

  always_comb begin
    for (int i = 0; i < CW; i++) begin
      slot_idx[i] = head + LT'(i);
    end
  end

  // Retire run stops at the first entry not ready or excepting.
  always_comb begin
    pop     = '0;
    k       = '0;
    scan_go = 1'b1;
    for (int i = 0; i < CW; i++) begin
      scan_go = scan_go
              & e_valid[slot_idx[i]]
              & e_done[slot_idx[i]]
              & ~e_exc[slot_idx[i]];
      pop[i]  = scan_go;
      k       = k + (LT+1)'(scan_go);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      e_valid <= '0;
      e_done  <= '0;
      e_exc   <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else if (flush) begin
      e_valid <= '0;
      e_done  <= '0;
      e_exc   <= '0;
      head    <= tail;
      count   <= '0;
    end else begin
      if (cmpl_hit) begin
        e_done[Cmpl_tag_IN] <= 1'b1;
        e_exc[Cmpl_tag_IN]  <= Cmpl_exc_IN;
      end
      if (disp_acc) begin
        e_valid[tail] <= 1'b1;
        e_done[tail]  <= 1'b0;
        e_exc[tail]   <= 1'b0;
        tail          <= tail + 1'b1;
      end
      for (int i = 0; i < CW; i++) begin
        if (pop[i]) begin
          e_valid[slot_idx[i]] <= 1'b0;
        end
      end
      head  <= head + k[LT-1:0];
      count <= count + (LT+1)'(disp_acc) - k;
    end
  end

  always_ff @(posedge CLK) begin
    if (disp_acc) begin
      e_has_dest[tail] <= Disp_has_dest_IN;
      e_arch[tail]     <= Disp_arch_IN;
      e_phys[tail]     <= Disp_phys_IN;
      e_old[tail]      <= Disp_old_phys_IN;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Flush_OUT           <= 1'b0;
      Commit_valid_OUT    <= '0;
      Commit_has_dest_OUT <= '0;
      Commit_arch_OUT     <= '0;
      Commit_phys_OUT     <= '0;
      Commit_free_OUT     <= '0;
    end else begin
      Flush_OUT <= flush;
      for (int i = 0; i < CW; i++) begin
        Commit_valid_OUT[i] <= pop[i];
        if (pop[i]) begin
          Commit_has_dest_OUT[i]    <= e_has_dest[slot_idx[i]];
          Commit_arch_OUT[i*LA +: LA] <= e_arch[slot_idx[i]];
          Commit_phys_OUT[i*LP +: LP] <= e_phys[slot_idx[i]];
          Commit_free_OUT[i*LP +: LP] <= e_old[slot_idx[i]];
        end else begin
          Commit_has_dest_OUT[i]    <= 1'b0;
          Commit_arch_OUT[i*LA +: LA] <= '0;
          Commit_phys_OUT[i*LP +: LP] <= '0;
          Commit_free_OUT[i*LP +: LP] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: queue model checked each cycle,
// plus directed scenarios with literal expectations.
module tb_rob_multi_commit;

  localparam int SIZE = 64;
  localparam int NA   = 32;
  localparam int NP   = 64;
  localparam int CW   = 2;
  localparam int LT   = 6;
  localparam int LA   = 5;
  localparam int LP   = 6;

  logic             CLK;
  logic             RESET;
  logic             Disp_valid_IN;
  logic             Disp_has_dest_IN;
  logic [LA-1:0]    Disp_arch_IN;
  logic [LP-1:0]    Disp_phys_IN;
  logic [LP-1:0]    Disp_old_phys_IN;
  logic             Disp_ready_OUT;
  logic [LT-1:0]    Disp_tag_OUT;
  logic             Cmpl_valid_IN;
  logic [LT-1:0]    Cmpl_tag_IN;
  logic             Cmpl_exc_IN;
  logic [CW-1:0]    Commit_valid_OUT;
  logic [CW-1:0]    Commit_has_dest_OUT;
  logic [CW*LA-1:0] Commit_arch_OUT;
  logic [CW*LP-1:0] Commit_phys_OUT;
  logic [CW*LP-1:0] Commit_free_OUT;
  logic             Flush_OUT;
  logic [LT:0]      Count_OUT;
  logic             Full_OUT;
  logic             Empty_OUT;

  rob_multi_commit #(
    .SIZE(SIZE), .NUM_ARCH_REGS(NA),
    .NUM_PHYS_REGS(NP), .COMMIT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .Disp_valid_IN(Disp_valid_IN),
    .Disp_has_dest_IN(Disp_has_dest_IN),
    .Disp_arch_IN(Disp_arch_IN),
    .Disp_phys_IN(Disp_phys_IN),
    .Disp_old_phys_IN(Disp_old_phys_IN),
    .Disp_ready_OUT(Disp_ready_OUT),
    .Disp_tag_OUT(Disp_tag_OUT),
    .Cmpl_valid_IN(Cmpl_valid_IN),
    .Cmpl_tag_IN(Cmpl_tag_IN),
    .Cmpl_exc_IN(Cmpl_exc_IN),
    .Commit_valid_OUT(Commit_valid_OUT),
    .Commit_has_dest_OUT(Commit_has_dest_OUT),
    .Commit_arch_OUT(Commit_arch_OUT),
    .Commit_phys_OUT(Commit_phys_OUT),
    .Commit_free_OUT(Commit_free_OUT),
    .Flush_OUT(Flush_OUT),
    .Count_OUT(Count_OUT),
    .Full_OUT(Full_OUT),
    .Empty_OUT(Empty_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: program-order queue of in-flight instructions.
  typedef struct {
    int tag; bit hd; int arch; int phys; int old; bit done; bit exc;
  } ent_t;

  ent_t q[$];
  int   mtail;
  int   mk;
  bit   mfull;
  logic [CW-1:0]    m_cv, m_hd;
  logic [CW*LA-1:0] m_arch;
  logic [CW*LP-1:0] m_phys, m_free;
  logic             m_flush;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      q.delete();
      mtail = 0;
      m_cv = '0; m_hd = '0; m_arch = '0;
      m_phys = '0; m_free = '0; m_flush = 1'b0;
    end else begin
      m_cv = '0; m_hd = '0; m_arch = '0;
      m_phys = '0; m_free = '0;
      mfull = (q.size() == SIZE);
      if (q.size() > 0 && q[0].done && q[0].exc) begin
        m_flush = 1'b1;
        q.delete();
      end else begin
        m_flush = 1'b0;
        mk = 0;
        while (mk < CW && mk < q.size() && q[mk].done && !q[mk].exc) begin
          m_cv[mk] = 1'b1;
          m_hd[mk] = q[mk].hd;
          m_arch[mk*LA +: LA] = LA'(q[mk].arch);
          m_phys[mk*LP +: LP] = LP'(q[mk].phys);
          m_free[mk*LP +: LP] = LP'(q[mk].old);
          mk++;
        end
        if (Cmpl_valid_IN) begin
          foreach (q[j]) begin
            if (q[j].tag == int'(Cmpl_tag_IN)) begin
              q[j].done = 1'b1;
              q[j].exc  = Cmpl_exc_IN;
            end
          end
        end
        if (Disp_valid_IN && !mfull) begin
          q.push_back('{mtail, Disp_has_dest_IN, int'(Disp_arch_IN),
                        int'(Disp_phys_IN), int'(Disp_old_phys_IN),
                        1'b0, 1'b0});
          mtail = (mtail + 1) % SIZE;
        end
        repeat (mk) void'(q.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (RESET && chk_en) begin
      chk("m_valid", 64'(Commit_valid_OUT), 64'(m_cv));
      chk("m_hd", 64'(Commit_has_dest_OUT), 64'(m_hd));
      chk("m_arch", 64'(Commit_arch_OUT), 64'(m_arch));
      chk("m_phys", 64'(Commit_phys_OUT), 64'(m_phys));
      chk("m_free", 64'(Commit_free_OUT), 64'(m_free));
      chk("m_flush", 64'(Flush_OUT), 64'(m_flush));
      chk("m_count", 64'(Count_OUT), 64'(q.size()));
      chk("m_full", 64'(Full_OUT), 64'(q.size() == SIZE));
      chk("m_empty", 64'(Empty_OUT), 64'(q.size() == 0));
      chk("m_ready", 64'(Disp_ready_OUT), 64'(q.size() != SIZE));
      chk("m_tag", 64'(Disp_tag_OUT), 64'(mtail));
    end
  end

  task automatic cyc(input bit dv, input int a, input bit cv,
                     input int ct, input bit ce);
    Disp_valid_IN    = dv;
    Disp_has_dest_IN = (a % 3) != 0;
    Disp_arch_IN     = LA'(a % NA);
    Disp_phys_IN     = LP'((a * 3 + 1) % NP);
    Disp_old_phys_IN = LP'((a * 5 + 2) % NP);
    Cmpl_valid_IN    = cv;
    Cmpl_tag_IN      = LT'(ct % SIZE);
    Cmpl_exc_IN      = ce;
    @(posedge CLK);
    #1;
    Disp_valid_IN = 1'b0;
    Cmpl_valid_IN = 1'b0;
    Cmpl_exc_IN   = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  int exp_seq = 0;

  task automatic grab();
    for (int s = 0; s < CW; s++) begin
      if (Commit_valid_OUT[s]) begin
        chk("wrap_arch", 64'(Commit_arch_OUT[s*LA +: LA]),
            64'(exp_seq % NA));
        exp_seq++;
      end
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_cv"}, 64'(Commit_valid_OUT), 0);
    chk({nm, "_arch"}, 64'(Commit_arch_OUT), 0);
    chk({nm, "_flush"}, 64'(Flush_OUT), 0);
    chk({nm, "_cnt"}, 64'(Count_OUT), 0);
    chk({nm, "_empty"}, 64'(Empty_OUT), 1);
    chk({nm, "_full"}, 64'(Full_OUT), 0);
    chk({nm, "_ready"}, 64'(Disp_ready_OUT), 1);
    chk({nm, "_tag"}, 64'(Disp_tag_OUT), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg;
    int pt;
    int wraps;
    RESET = 1'b0;
    Disp_valid_IN = 1'b0; Disp_has_dest_IN = 1'b0;
    Disp_arch_IN = '0; Disp_phys_IN = '0; Disp_old_phys_IN = '0;
    Cmpl_valid_IN = 1'b0; Cmpl_tag_IN = '0; Cmpl_exc_IN = 1'b0;
    #12;
    chk_reset_vals("rst");
    #1 RESET = 1'b1;
    chk_en = 1'b1;

    // Out-of-order completion lets tags 0 and 1 retire together.
    cyc(1, 1, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 3, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    chk("t1_cnt3", 64'(Count_OUT), 3);
    chk("t1_none", 64'(Commit_valid_OUT), 0);
    cyc(0, 0, 1, 2, 0);
    chk("t1_pair", 64'(Commit_valid_OUT), 2'b11);
    chk("t1_a0", 64'(Commit_arch_OUT[LA-1:0]), 1);
    chk("t1_a1", 64'(Commit_arch_OUT[2*LA-1:LA]), 2);
    chk("t1_cnt1", 64'(Count_OUT), 1);
    idle();
    chk("t1_single", 64'(Commit_valid_OUT), 2'b01);
    chk("t1_a2", 64'(Commit_arch_OUT[LA-1:0]), 3);
    chk("t1_cnt0", 64'(Count_OUT), 0);

    // Tags 3..6: hole at tag 5 stalls retirement.
    cyc(1, 4, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    cyc(1, 6, 0, 0, 0);
    cyc(1, 7, 1, 4, 0);
    cyc(0, 0, 1, 6, 0);
    cyc(0, 0, 1, 3, 0);
    idle();
    chk("t2_pair", 64'(Commit_valid_OUT), 2'b11);
    chk("t2_a0", 64'(Commit_arch_OUT[LA-1:0]), 4);
    chk("t2_a1", 64'(Commit_arch_OUT[2*LA-1:LA]), 5);
    chk("t2_cnt2", 64'(Count_OUT), 2);
    idle();
    chk("t2_stall", 64'(Commit_valid_OUT), 0);
    cyc(0, 0, 1, 5, 0);
    chk("t2_nobypass", 64'(Commit_valid_OUT), 0);
    idle();
    chk("t2_pair2", 64'(Commit_valid_OUT), 2'b11);
    chk("t2_a2", 64'(Commit_arch_OUT[LA-1:0]), 6);
    chk("t2_a3", 64'(Commit_arch_OUT[2*LA-1:LA]), 7);
    chk("t2_cnt0", 64'(Count_OUT), 0);

    // Fill from tag 7 to full.
    chk("t3_tag7", 64'(Disp_tag_OUT), 7);
    for (int i = 0; i < SIZE; i++) cyc(1, i, 0, 0, 0);
    chk("t3_full", 64'(Full_OUT), 1);
    chk("t3_ready", 64'(Disp_ready_OUT), 0);
    chk("t3_cnt", 64'(Count_OUT), SIZE);
    cyc(1, 99, 0, 0, 0);
    chk("t3_drop_cnt", 64'(Count_OUT), SIZE);
    chk("t3_drop_tag", 64'(Disp_tag_OUT), 7);
    cyc(0, 0, 1, 7, 0);
    cyc(1, 40, 0, 0, 0);
    chk("t3_commit", 64'(Commit_valid_OUT), 2'b01);
    chk("t3_carch", 64'(Commit_arch_OUT[LA-1:0]), 0);
    chk("t3_cnt63", 64'(Count_OUT), SIZE - 1);
    chk("t3_tag_hold", 64'(Disp_tag_OUT), 7);
    cyc(1, 41, 0, 0, 0);
    chk("t3_refill", 64'(Count_OUT), SIZE);
    chk("t3_tag8", 64'(Disp_tag_OUT), 8);
    for (int i = 0; i < SIZE; i++) cyc(0, 0, 1, (8 + i) % SIZE, 0);
    repeat (3) idle();
    chk("t3_empty", 64'(Empty_OUT), 1);

    // Exception on tag 9 flushes; tag 10 never retires.
    cyc(1, 10, 0, 0, 0);
    cyc(1, 11, 0, 0, 0);
    cyc(1, 12, 1, 9, 1);
    cyc(0, 0, 1, 8, 0);
    cyc(0, 0, 1, 10, 0);
    chk("t4_c0", 64'(Commit_valid_OUT), 2'b01);
    chk("t4_a0", 64'(Commit_arch_OUT[LA-1:0]), 10);
    chk("t4_cnt2", 64'(Count_OUT), 2);
    chk("t4_noflush", 64'(Flush_OUT), 0);
    cyc(1, 13, 1, 10, 0);
    chk("t4_flush", 64'(Flush_OUT), 1);
    chk("t4_fl_cv", 64'(Commit_valid_OUT), 0);
    chk("t4_fl_cnt", 64'(Count_OUT), 0);
    chk("t4_fl_tag", 64'(Disp_tag_OUT), 11);
    idle();
    chk("t4_pulse", 64'(Flush_OUT), 0);
    chk("t4_after", 64'(Commit_valid_OUT), 0);

    // Stream 3*SIZE in-order completions across tag wrap.
    tg = 11;
    wraps = 0;
    for (int i = 0; i < 3 * SIZE; i++) begin
      pt = int'(Disp_tag_OUT);
      cyc(1, i % NA, i > 0, (tg + SIZE - 1) % SIZE, 0);
      tg = (tg + 1) % SIZE;
      grab();
      if (pt == SIZE - 1 && Disp_tag_OUT == '0) wraps++;
    end
    cyc(0, 0, 1, (tg + SIZE - 1) % SIZE, 0);
    grab();
    repeat (3) begin
      idle();
      grab();
    end
    chk("wrap_n", 64'(exp_seq), 3 * SIZE);
    chk("tag_wraps", 64'(wraps), 3);

    // Asynchronous reset with 5 entries in flight.
    for (int i = 0; i < 5; i++) cyc(1, 20 + i, 0, 0, 0);
    chk("t6_cnt5", 64'(Count_OUT), 5);
    #2 RESET = 1'b0;
    #1 chk_reset_vals("mid_rst");
    #3 RESET = 1'b1;
    chk("t6_tag0", 64'(Disp_tag_OUT), 0);
    cyc(1, 30, 0, 0, 0);
    chk("t6_cnt1", 64'(Count_OUT), 1);
    chk("t6_tag1", 64'(Disp_tag_OUT), 1);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
